// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the command/result records
// carried through the issue queue.
package alu_pkg;

  localparam int ALU_W = 8;

  localparam logic [2:0] ADD_U = 3'b000;
  localparam logic [2:0] ADD_S = 3'b001;
  localparam logic [2:0] SUB_U = 3'b010;
  localparam logic [2:0] SUB_S = 3'b011;
  localparam logic [2:0] AND   = 3'b100;
  localparam logic [2:0] OR    = 3'b101;
  localparam logic [2:0] XOR   = 3'b110;
  localparam logic [2:0] DIV2  = 3'b111;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } cmd_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [ALU_W-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
  } res_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO without bypass; head is presented combinationally and reads
// as zero while empty. Pointers carry one extra bit to separate full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << AW;

  logic [WIDTH-1:0] mem [SLOTS];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Storage slots may outnumber DEPTH when DEPTH is not a power of two.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Command queue and credit-controlled result buffer around an ALU.
// Optional feature macro: ALU_ISSUE_STICKY_EN (sticky carry/overflow flags).
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int NUMBITS = ALU_W,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_opcode,
  input  logic [NUMBITS-1:0]       in_a,
  input  logic [NUMBITS-1:0]       in_b,
  output logic [NUMBITS-1:0]       alu_a,
  output logic [NUMBITS-1:0]       alu_b,
  output logic [2:0]               alu_opcode,
  output logic                     alu_issue,
  input  logic [NUMBITS-1:0]       alu_result,
  input  logic                     alu_carryout,
  input  logic                     alu_overflow,
  input  logic                     alu_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUMBITS-1:0]       out_result,
  output logic [2:0]               out_opcode,
  output logic                     out_carry,
  output logic                     out_overflow,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   cmd_count,
  input  logic                     clr_sticky,
  output logic [1:0]               sticky_flags
);

  localparam int RES_DEPTH = ALU_LAT + 2;
  localparam int CW        = $clog2(RES_DEPTH + 1);

  cmd_t                        cmd_in;
  cmd_t                        cmd_head;
  res_t                        res_in;
  res_t                        res_head;
  logic                        cmd_full;
  logic                        cmd_empty;
  logic                        res_full;
  logic                        res_empty;
  logic [$clog2(RES_DEPTH):0]  res_count;
  logic [CW-1:0]               credits;
  logic [ALU_LAT-1:0]          pipe_valid;
  logic [2:0]                  pipe_op [ALU_LAT];
  logic                        out_fire;
  logic                        unused_res;

  assign cmd_in   = '{opcode: in_opcode, a: in_a, b: in_b};
  assign in_ready = !cmd_full;

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (alu_issue),
    .wdata (cmd_in),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  assign alu_issue  = !cmd_empty && (credits != '0);
  assign alu_a      = cmd_head.a;
  assign alu_b      = cmd_head.b;
  assign alu_opcode = cmd_head.opcode;
  assign out_fire   = out_valid && out_ready;

  // One credit per result slot guarantees every in-flight op has a landing place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= CW'(RES_DEPTH);
    end else begin
      case ({alu_issue, out_fire})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Issue tag and opcode travel alongside the op until its result appears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < ALU_LAT; i++) pipe_op[i] <= 3'b000;
    end else begin
      pipe_valid[0] <= alu_issue;
      pipe_op[0]    <= cmd_head.opcode;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_op[i]    <= pipe_op[i-1];
      end
    end
  end

  assign res_in = '{opcode:   pipe_op[ALU_LAT-1],
                    result:   alu_result,
                    carry:    alu_carryout,
                    overflow: alu_overflow,
                    zero:     alu_zero};

  sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pipe_valid[ALU_LAT-1]),
    .pop   (out_fire),
    .wdata (res_in),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  assign unused_res   = res_full ^ (^res_count);
  assign out_valid    = !res_empty;
  assign out_result   = res_head.result;
  assign out_opcode   = res_head.opcode;
  assign out_carry    = res_head.carry;
  assign out_overflow = res_head.overflow;
  assign out_zero     = res_head.zero;

`ifdef ALU_ISSUE_STICKY_EN
  logic [1:0] sticky_r;

  // Clear has priority over accumulation from a coincident handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_r <= 2'b00;
    end else if (clr_sticky) begin
      sticky_r <= 2'b00;
    end else if (out_fire) begin
      sticky_r <= sticky_r | {out_overflow, out_carry};
    end else begin
      sticky_r <= sticky_r;
    end
  end

  assign sticky_flags = sticky_r;
`else
  logic unused_clr;
  assign unused_clr   = clr_sticky;
  assign sticky_flags = 2'b00;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue with a one-cycle ALU model.
module tb_alu_issue_queue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [2:0] in_opcode;
  logic [7:0] in_a, in_b;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic       alu_issue;
  logic [7:0] alu_result;
  logic       alu_carryout, alu_overflow, alu_zero;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [2:0] out_opcode;
  logic       out_carry, out_overflow, out_zero;
  logic [2:0] cmd_count;
  logic       clr_sticky;
  logic [1:0] sticky_flags;

  int          checks = 0;
  int          errors = 0;
  int          issue_cnt;
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  logic [13:0] cur_exp;
  logic [9:0]  alu_q;

  always #5 clk = ~clk;

  alu_issue_queue #(.NUMBITS(8), .DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_issue(alu_issue),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_opcode(out_opcode), .out_carry(out_carry), .out_overflow(out_overflow),
    .out_zero(out_zero), .cmd_count(cmd_count), .clr_sticky(clr_sticky),
    .sticky_flags(sticky_flags)
  );

  // Stand-in for myalu: {carry, overflow, result}, registered once.
  function automatic logic [9:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0; v = 1'b0; s = 9'd0;
    case (op)
      ADD_U: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      ADD_S: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                   v = (a[7] == b[7]) && (r[7] != a[7]); end
      SUB_U: begin r = a - b; c = (a < b); end
      SUB_S: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
      AND:   r = a & b;
      OR:    r = a | b;
      XOR:   r = a ^ b;
      default: r = {a[7], a[7:1]};
    endcase
    return {c, v, r};
  endfunction

  always @(posedge clk) alu_q <= alu_model(alu_opcode, alu_a, alu_b);
  assign alu_carryout = alu_q[9];
  assign alu_overflow = alu_q[8];
  assign alu_result   = alu_q[7:0];
  assign alu_zero     = (alu_q[7:0] == 8'h00);

  task automatic sample();
    @(negedge clk);
    if (reset && in_valid && in_ready) exp_q.push_back(cur_exp);
    if (reset && out_valid && out_ready)
      obs_q.push_back({out_opcode, out_result, out_carry, out_overflow, out_zero});
    if (reset && alu_issue) issue_cnt++;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [13:0] e);
    in_valid = v; in_opcode = op; in_a = a; in_b = b; cur_exp = e;
  endtask

  task automatic clear_q();
    exp_q.delete(); obs_q.delete(); issue_cnt = 0;
  endtask

  task automatic test_reset();
    sample();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if ({out_result, out_opcode, out_carry, out_overflow, out_zero} !== 14'h0) begin
      errors++; $display("FAIL rst_out_data got %h exp 0", {out_result, out_opcode, out_carry, out_overflow, out_zero}); end
    checks++; if ({alu_issue, alu_a, alu_b, alu_opcode} !== 20'h0) begin
      errors++; $display("FAIL rst_alu got %h exp 0", {alu_issue, alu_a, alu_b, alu_opcode}); end
    checks++; if (cmd_count !== 3'd0) begin errors++; $display("FAIL rst_cmd_count got %0d exp 0", cmd_count); end
    checks++; if (sticky_flags !== 2'b00) begin errors++; $display("FAIL rst_sticky got %b exp 00", sticky_flags); end
    adv();
  endtask

  task automatic test_single();
    clear_q();
    out_ready = 1'b1;
    drive(1'b1, ADD_U, 8'hFF, 8'h01, {ADD_U, 8'h00, 1'b1, 1'b0, 1'b1});
    sample(); adv();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 14'h0);
    sample();
    checks++; if (alu_issue !== 1'b1 || alu_a !== 8'hFF || alu_b !== 8'h01) begin
      errors++; $display("FAIL single_issue got %b/%h/%h exp 1/ff/01", alu_issue, alu_a, alu_b); end
    adv(); sample();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", out_valid); end
    adv(); sample();
    checks++; if ({out_valid, out_opcode, out_result, out_carry, out_zero} !== {1'b1, ADD_U, 8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL single_out got v%b op%h r%h c%b z%b exp v1 op0 r00 c1 z1",
                         out_valid, out_opcode, out_result, out_carry, out_zero); end
    adv(); sample(); adv();
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL single_count got %0d outputs exp 1", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    out_ready = 1'b1;
    drive(1'b1, ADD_S, 8'h7F, 8'h01, {ADD_S, 8'h80, 1'b0, 1'b1, 1'b0});
    sample(); adv();
    drive(1'b1, SUB_U, 8'h00, 8'h01, {SUB_U, 8'hFF, 1'b1, 1'b0, 1'b0});
    sample(); adv();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 14'h0);
    sample(); adv(); sample();
    checks++; if ({out_valid, out_opcode, out_result, out_overflow} !== {1'b1, ADD_S, 8'h80, 1'b1}) begin
      errors++; $display("FAIL b2b_first got v%b op%h r%h ov%b exp v1 op1 r80 ov1",
                         out_valid, out_opcode, out_result, out_overflow); end
    adv(); sample();
    checks++; if ({out_valid, out_opcode, out_result} !== {1'b1, SUB_U, 8'hFF}) begin
      errors++; $display("FAIL b2b_second got v%b op%h r%h exp v1 op2 rff", out_valid, out_opcode, out_result); end
    adv(); sample();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_after got %b exp 0", out_valid); end
    adv();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_order[%0d] got %h exp %h", i, (i < obs_q.size()) ? obs_q[i] : 14'h3fff, exp_q[i]); end
    end
  endtask

  task automatic drain_and_compare(input string name, input int expected_n);
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin sample(); adv(); end
    checks++; if (obs_q.size() != expected_n || exp_q.size() != expected_n) begin
      errors++; $display("FAIL %s_count got %0d outputs %0d accepted exp %0d", name, obs_q.size(), exp_q.size(), expected_n); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s_order[%0d] got %h exp %h", name, i, (i < obs_q.size()) ? obs_q[i] : 14'h3fff, exp_q[i]); end
    end
    checks++; if (out_valid !== 1'b0 || cmd_count !== 3'd0) begin
      errors++; $display("FAIL %s_empty got v%b cnt%0d exp v0 cnt0", name, out_valid, cmd_count); end
  endtask

  task automatic test_backpressure();
    int idx;
    clear_q();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, ADD_U, 8'(idx), 8'h10, {ADD_U, 8'h10 + 8'(idx), 3'b000});
      sample();
      if (in_ready) idx++;
      adv();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00, 14'h0);
    for (int c = 0; c < 3; c++) begin sample(); adv(); end
    sample();
    checks++; if (issue_cnt != 3) begin errors++; $display("FAIL bp_issues got %0d exp 3", issue_cnt); end
    checks++; if (exp_q.size() != 7) begin errors++; $display("FAIL bp_accepted got %0d exp 7", exp_q.size()); end
    checks++; if (cmd_count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full got cnt%0d rdy%b exp cnt4 rdy0", cmd_count, in_ready); end
    checks++; if (out_valid !== 1'b1 || obs_q.size() != 0) begin
      errors++; $display("FAIL bp_hold got v%b n%0d exp v1 n0", out_valid, obs_q.size()); end
    adv();
    drain_and_compare("bp", 7);
  endtask

  task automatic test_full_push_pop();
    int idx;
    clear_q();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 20 && idx < 7; c++) begin
      drive(1'b1, ADD_U, 8'h20 + 8'(idx), 8'h10, {ADD_U, 8'h30 + 8'(idx), 3'b000});
      sample();
      if (in_ready) idx++;
      adv();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00, 14'h0);
    sample();
    checks++; if (cmd_count !== 3'd4) begin errors++; $display("FAIL fpp_fill got %0d exp 4", cmd_count); end
    adv();
    out_ready = 1'b1;
    sample();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fpp_release got %b exp 1", out_valid); end
    adv();
    out_ready = 1'b0;
    drive(1'b1, ADD_U, 8'h40, 8'h10, {ADD_U, 8'h50, 3'b000});
    sample();
    checks++; if ({alu_issue, in_ready, cmd_count} !== {1'b1, 1'b0, 3'd4}) begin
      errors++; $display("FAIL fpp_refuse got iss%b rdy%b cnt%0d exp iss1 rdy0 cnt4", alu_issue, in_ready, cmd_count); end
    adv(); sample();
    checks++; if ({alu_issue, in_ready, cmd_count} !== {1'b0, 1'b1, 3'd3}) begin
      errors++; $display("FAIL fpp_accept got iss%b rdy%b cnt%0d exp iss0 rdy1 cnt3", alu_issue, in_ready, cmd_count); end
    adv();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 14'h0);
    sample();
    checks++; if (cmd_count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fpp_refill got cnt%0d rdy%b exp cnt4 rdy0", cmd_count, in_ready); end
    adv();
    drain_and_compare("fpp", 8);
  endtask

  task automatic test_reset_mid();
    int stale;
    clear_q();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, OR, 8'(c), 8'hA0, {OR, 8'hA0 | 8'(c), 3'b000});
      sample(); adv();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00, 14'h0);
    sample(); adv();
    checks++; if (out_valid !== 1'b1 || dut.pipe_valid[0] !== 1'b1) begin
      errors++; $display("FAIL rmid_setup got v%b pipe%b exp 1/1", out_valid, dut.pipe_valid[0]); end
    reset = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready, cmd_count, alu_issue} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
      errors++; $display("FAIL rmid_cleared got v%b rdy%b cnt%0d iss%b exp v0 rdy1 cnt0 iss0",
                         out_valid, in_ready, cmd_count, alu_issue); end
    @(negedge clk);
    reset = 1'b1;
    adv();
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (out_valid) stale++;
      adv();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rmid_stale got %0d cycles exp 0", stale); end
  endtask

  task automatic test_sticky();
    clear_q();
    out_ready = 1'b1;
    drive(1'b1, ADD_S, 8'h7F, 8'h01, {ADD_S, 8'h80, 1'b0, 1'b1, 1'b0});
    sample(); adv();
    drive(1'b1, AND, 8'h0F, 8'hF0, {AND, 8'h00, 1'b0, 1'b0, 1'b1});
    sample(); adv();
    drive(1'b0, 3'b000, 8'h00, 8'h00, 14'h0);
    for (int c = 0; c < 5; c++) begin sample(); adv(); end
    sample();
`ifdef ALU_ISSUE_STICKY_EN
    checks++; if (sticky_flags !== 2'b10) begin errors++; $display("FAIL sticky_set got %b exp 10", sticky_flags); end
`else
    checks++; if (sticky_flags !== 2'b00) begin errors++; $display("FAIL sticky_off got %b exp 00", sticky_flags); end
`endif
    adv();
    clr_sticky = 1'b1;
    sample(); adv();
    clr_sticky = 1'b0;
    sample();
    checks++; if (sticky_flags !== 2'b00) begin errors++; $display("FAIL sticky_clr got %b exp 00", sticky_flags); end
    checks++; if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL sticky_out got %0d outputs exp 2", obs_q.size()); end
    adv();
  endtask

  initial begin
    reset = 1'b0; clr_sticky = 1'b0; out_ready = 1'b0; issue_cnt = 0;
    drive(1'b0, 3'b000, 8'h00, 8'h00, 14'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    adv();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid();
    test_sticky();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
